// File: rtl/adder_if.sv
// ---------------------------------------------------------------------------
// adder_if
//   Operand/result bundle for the registered adder stage.
//   a    : operand a (A_W bits, unsigned), driven by the upstream multiplier
//   b    : operand b (B_W bits, unsigned), the running partial sum
//   out  : registered sum (B_W bits)
//   ovf  : registered carry-out flag belonging to the same sample as out
//   Modports: master drives operands and observes results; slave (the adder)
//   consumes operands and drives results.
// ---------------------------------------------------------------------------
interface adder_if #(
    parameter int A_W = 8,
    parameter int B_W = 12
);
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic [B_W-1:0] out;
    logic           ovf;

    modport master (output a, output b, input out, input ovf);
    modport slave  (input a, input b, output out, output ovf);
endinterface

// File: rtl/adder.sv
// ---------------------------------------------------------------------------
// adder
//   Registered unsigned adder between the multiplier and accumulator stages.
//   Adds a zero-extended A_W-bit operand to a B_W-bit operand every cycle and
//   registers the B_W-bit result plus the carry-out. One-cycle latency, no
//   handshake.
//   Parameters:
//     A_W      : width of operand a (must not exceed B_W)
//     B_W      : width of operand b and of the result
//     SATURATE : 0 = wrap modulo 2^B_W, 1 = clamp to 2^B_W-1 on carry-out
//   Ports:
//     clk   : clock, rising edge
//     rst_n : asynchronous active-low reset, clears out and ovf immediately
//     bus   : adder_if slave modport (a, b in; out, ovf out). The interface
//             instance must be parameterised with the same A_W/B_W.
// ---------------------------------------------------------------------------
module adder #(
    parameter int A_W      = 8,
    parameter int B_W      = 12,
    parameter bit SATURATE = 1'b0
) (
    input  logic    clk,
    input  logic    rst_n,
    adder_if.slave  bus
);

    logic [B_W:0]   a_ext;
    logic [B_W:0]   sum;
    logic [B_W-1:0] result;

    logic [B_W-1:0] out_d;
    logic [B_W-1:0] out_q;
    logic           ovf_d;
    logic           ovf_q;

    // One extra bit of headroom so the carry-out is captured in sum[B_W].
    assign a_ext = {{(B_W + 1 - A_W){1'b0}}, bus.a};
    assign sum   = a_ext + {1'b0, bus.b};

    generate
        if (SATURATE) begin : g_sat
            assign result = sum[B_W] ? {B_W{1'b1}} : sum[B_W-1:0];
        end else begin : g_wrap
            assign result = sum[B_W-1:0];
        end
    endgenerate

    always_comb begin
        out_d = result;
        ovf_d = sum[B_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            out_q <= out_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.out = out_q;
    assign bus.ovf = ovf_q;

endmodule

// File: tb/tb_adder.sv
// ---------------------------------------------------------------------------
// tb_adder
//   Directed test of the registered adder. Two instances share clock, reset
//   and operands: one wrapping (SATURATE=0), one clamping (SATURATE=1).
//   Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_adder;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    adder_if #(.A_W(8), .B_W(12)) bus_w ();
    adder_if #(.A_W(8), .B_W(12)) bus_s ();

    adder #(.A_W(8), .B_W(12), .SATURATE(1'b0)) dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_w.slave)
    );

    adder #(.A_W(8), .B_W(12), .SATURATE(1'b1)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] a, input logic [11:0] b);
        bus_w.a = a;
        bus_w.b = b;
        bus_s.a = a;
        bus_s.b = b;
    endtask

    // Drive operands at the falling edge, then sample just after the rising edge.
    task automatic step(input string tag, input logic [7:0] a, input logic [11:0] b,
                        input logic [11:0] exp_w, input logic exp_wovf,
                        input logic [11:0] exp_s, input logic exp_sovf);
        @(negedge clk);
        drive(a, b);
        @(posedge clk);
        #1;
        $display("txn %s a=%0d b=%0d wrap=%0d/%0d sat=%0d/%0d", tag, a, b,
                 bus_w.out, bus_w.ovf, bus_s.out, bus_s.ovf);
        check({tag, "_wout"}, bus_w.out, exp_w);
        check({tag, "_wovf"}, {11'd0, bus_w.ovf}, {11'd0, exp_wovf});
        check({tag, "_sout"}, bus_s.out, exp_s);
        check({tag, "_sovf"}, {11'd0, bus_s.ovf}, {11'd0, exp_sovf});
    endtask

    logic [7:0]  seq_a [6];
    logic [11:0] seq_b [6];
    logic [11:0] seq_e [6];

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(8'd0, 12'd0);

        seq_a = '{8'd1, 8'd3, 8'd15, 8'd7, 8'd20, 8'd9};
        seq_b = '{12'd2, 12'd3, 12'd11, 12'd4, 12'd5, 12'd7};
        seq_e = '{12'd3, 12'd6, 12'd26, 12'd11, 12'd25, 12'd16};

        // Reset state before any clock edge.
        #2;
        check("reset_out", bus_w.out, 12'd0);
        check("reset_ovf", {11'd0, bus_w.ovf}, 12'd0);

        // Reset held across an edge with nonzero operands keeps outputs at 0.
        drive(8'd200, 12'd300);
        @(posedge clk);
        #1;
        check("reset_hold_out", bus_w.out, 12'd0);
        check("reset_hold_sout", bus_s.out, 12'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1. Basic sequence, no overflow.
        for (int i = 0; i < 6; i++) begin
            step($sformatf("seq%0d", i), seq_a[i], seq_b[i], seq_e[i], 1'b0, seq_e[i], 1'b0);
        end

        // 2. Asynchronous reset between edges.
        step("pre_rst", 8'd15, 12'd11, 12'd26, 1'b0, 12'd26, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        $display("txn async_rst wrap=%0d/%0d sat=%0d/%0d", bus_w.out, bus_w.ovf, bus_s.out, bus_s.ovf);
        check("async_rst_wout", bus_w.out, 12'd0);
        check("async_rst_wovf", {11'd0, bus_w.ovf}, 12'd0);
        check("async_rst_sout", bus_s.out, 12'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 8'd7, 12'd4, 12'd11, 1'b0, 12'd11, 1'b0);

        // 3/4. Wrap versus saturate at the top of the range.
        step("max", 8'd255, 12'd4095, 12'd254, 1'b1, 12'd4095, 1'b1);
        step("fill", 8'd1, 12'd4094, 12'd4095, 1'b0, 12'd4095, 1'b0);
        step("carry0", 8'd255, 12'd3841, 12'd0, 1'b1, 12'd4095, 1'b1);
        step("a0_bmax", 8'd0, 12'd4095, 12'd4095, 1'b0, 12'd4095, 1'b0);

        // 5. Operand change just after an edge does not reach out until the next edge.
        step("lat_base", 8'd7, 12'd4, 12'd11, 1'b0, 12'd11, 1'b0);
        drive(8'd100, 12'd100);
        #3;
        $display("txn lat_hold wrap=%0d sat=%0d", bus_w.out, bus_s.out);
        check("lat_hold_wout", bus_w.out, 12'd11);
        check("lat_hold_sout", bus_s.out, 12'd11);
        @(posedge clk);
        #1;
        $display("txn lat_next wrap=%0d sat=%0d", bus_w.out, bus_s.out);
        check("lat_next_wout", bus_w.out, 12'd200);

        // 6. Zero operands after a nonzero result.
        step("zero", 8'd0, 12'd0, 12'd0, 1'b0, 12'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
